mic_start_screen_anim: RTL

Animated, parametrised successor to the static microphone start screen on the 96x64 RGB565 OLED. Answers per-pixel colour queries from the OLED driver with one registered cycle of latency. Drives a frame-synchronised state machine: the microphone icon slides in, then the "TEST" text box blinks. A live mic-level bar is overlaid and sampled once per frame to avoid tearing. Sits between the top-level screen mux and the OLED driver's pixel-index decode.

---
 rtl/mic_start_screen_anim.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mic_start_screen_anim.sv
// Animated mic start screen: slide-in icon, blinking text box, per-frame level bar.
// Pixel colour registered one cycle after (x,y); accepts a query every cycle, never stalls.
module mic_start_screen_anim #(
  parameter int          W            = 96,
  parameter int          H            = 64,
  parameter int          SLIDE_START  = 32,
  parameter int          BLINK_FRAMES = 30,
  parameter int          LEVEL_W      = 4,
  parameter logic [15:0] FG_COLOR     = 16'h0000,
  parameter logic [15:0] BG_COLOR     = 16'hFFFF,
  parameter logic [15:0] ACCENT_COLOR = 16'h07E0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_begin,
  input  logic               start,
  input  logic               ack,
  input  logic [6:0]         x,
  input  logic [5:0]         y,
  input  logic [LEVEL_W-1:0] mic_level,
  output logic [15:0]        oled_data,
  output logic               busy,
  output logic               done
);

  localparam int FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [6:0]     X_MAX    = 7'(W - 1);
  localparam logic [5:0]     Y_MAX    = 6'(H - 1);
  localparam logic [FCW-1:0] FC_LAST  = FCW'(BLINK_FRAMES - 1);
  localparam logic [5:0]     OFF_INIT = 6'(SLIDE_START);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SLIDE_IN = 2'd1,
    BLINK    = 2'd2
  } state_t;

  state_t             state_q;
  logic [5:0]         offset_q;
  logic [FCW-1:0]     frame_cnt_q;
  logic               text_vis_q;
  logic [LEVEL_W-1:0] lvl_q;
  logic [15:0]        oled_data_q;
  logic               busy_q;
  logic               done_q;

  logic [15:0] pix_d;
  logic [7:0]  xo;
  logic [7:0]  y8;
  logic [7:0]  bar_lo;
  logic        in_range;
  logic        active;
  logic        x_ge_off;
  logic        hit_bar;
  logic        hit_icon;
  logic        hit_text;

  always_comb begin
    xo       = {1'b0, x} - {2'b0, offset_q};
    y8       = {2'b0, y};
    // 8-bit wrap is intended: lvl = 0 gives an empty bar
    bar_lo   = 8'd55 - 8'({lvl_q, 1'b0});
    in_range = (x <= X_MAX) && (y <= Y_MAX);
    active   = (state_q == SLIDE_IN) || (state_q == BLINK);
    x_ge_off = (x >= {1'b0, offset_q});

    hit_bar  = (x >= 7'd8) && (x <= 7'd11) && (y8 <= 8'd55) && (y8 > bar_lo);

    hit_icon = x_ge_off && (
                 ((xo >= 8'd40) && (xo <= 8'd47) && (y >= 6'd14) && (y <= 6'd29)) ||
                 ((xo >= 8'd43) && (xo <= 8'd44) && (y >= 6'd30) && (y <= 6'd37)) ||
                 ((xo >= 8'd38) && (xo <= 8'd49) && (y == 6'd38)));

    hit_text = (state_q == BLINK) && text_vis_q &&
               (x >= 7'd56) && (x <= 7'd79) && (y >= 6'd29) && (y <= 6'd43);

    pix_d = BG_COLOR;
    if (in_range && active) begin
      if (hit_bar)       pix_d = ACCENT_COLOR;
      else if (hit_icon) pix_d = FG_COLOR;
      else if (hit_text) pix_d = FG_COLOR;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      offset_q    <= 6'd0;
      frame_cnt_q <= '0;
      text_vis_q  <= 1'b0;
      lvl_q       <= '0;
      oled_data_q <= BG_COLOR;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      oled_data_q <= pix_d;
      done_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= SLIDE_IN;
            offset_q <= OFF_INIT;
            busy_q   <= 1'b1;
          end
        end
        SLIDE_IN: begin
          if (ack) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            lvl_q   <= '0;
          end else if (frame_begin) begin
            lvl_q <= mic_level;
            // offset 0 is only reachable here when SLIDE_START is 0
            if (offset_q <= 6'd2) begin
              offset_q    <= 6'd0;
              state_q     <= BLINK;
              frame_cnt_q <= '0;
              text_vis_q  <= 1'b1;
            end else begin
              offset_q <= offset_q - 6'd2;
            end
          end
        end
        BLINK: begin
          if (ack) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            lvl_q   <= '0;
          end else if (frame_begin) begin
            lvl_q <= mic_level;
            if (frame_cnt_q == FC_LAST) begin
              frame_cnt_q <= '0;
              text_vis_q  <= ~text_vis_q;
            end else begin
              frame_cnt_q <= frame_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign oled_data = oled_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
